// File: rtl/shift_pipeline_if.sv
// Handshake bundle for shift_pipeline.
// Input side:  in_valid/in_ready with in_data, in_shamt, in_op, in_tag.
// Output side: out_valid/out_ready with out_data, out_tag.
// master = producer/consumer environment, slave = the shifter pipeline.
interface shift_pipeline_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_pipeline.sv
// 5-stage registered barrel shifter (SLL / SRA) with elastic valid/ready stages.
// Stage k applies a fixed shift of 16/8/4/2/1 when its shamt bit is set; a dest
// tag rides alongside the data and is returned unchanged.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   flush    synchronous drop of all in-flight ops (beats a simultaneous input)
//   busy     OR of all stage valids
//   bus      shift_pipeline_if.slave: input and output handshakes
module shift_pipeline #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    output logic                  busy,
    shift_pipeline_if.slave       bus
);

    localparam int unsigned STAGES = SHAMT_W;

    // Fixed-distance shift; SRA fills vacated MSBs with the carried sign bit.
    function automatic logic [WIDTH-1:0] shift_fixed(
        input logic [WIDTH-1:0] d,
        input int unsigned      amt,
        input logic             op,
        input logic             sign
    );
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> amt);
        if (op) begin
            return (d >> amt) | (sign ? fill : '0);
        end
        return d << amt;
    endfunction

    logic               r_v     [STAGES];
    logic [WIDTH-1:0]   r_data  [STAGES];
    logic [SHAMT_W-1:0] r_shamt [STAGES];
    logic               r_op    [STAGES];
    logic               r_sign  [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];

    logic               w_src_v     [STAGES];
    logic [WIDTH-1:0]   w_src_data  [STAGES];
    logic [SHAMT_W-1:0] w_src_shamt [STAGES];
    logic               w_src_op    [STAGES];
    logic               w_src_sign  [STAGES];
    logic [TAG_W-1:0]   w_src_tag   [STAGES];
    logic [WIDTH-1:0]   w_nxt_data  [STAGES];
    logic [STAGES-1:0]  w_rdy;

    // Ready chain from the output back to stage 0; a stage may load if it is
    // empty or everything downstream of it can move.
    always_comb begin
        logic [STAGES-1:0] rdy;
        rdy = '0;
        rdy[STAGES-1] = ~r_v[STAGES-1] | bus.out_ready;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            rdy[i] = ~r_v[i] | rdy[i+1];
        end
        w_rdy = rdy;
    end

    // Per-stage source selection and shift.
    always_comb begin
        for (int i = 0; i < int'(STAGES); i++) begin
            if (i == 0) begin
                w_src_v[i]     = bus.in_valid;
                w_src_data[i]  = bus.in_data;
                w_src_shamt[i] = bus.in_shamt;
                w_src_op[i]    = bus.in_op;
                w_src_sign[i]  = bus.in_data[WIDTH-1];
                w_src_tag[i]   = bus.in_tag;
            end else begin
                w_src_v[i]     = r_v[i-1];
                w_src_data[i]  = r_data[i-1];
                w_src_shamt[i] = r_shamt[i-1];
                w_src_op[i]    = r_op[i-1];
                w_src_sign[i]  = r_sign[i-1];
                w_src_tag[i]   = r_tag[i-1];
            end
            if (w_src_shamt[i][int'(SHAMT_W) - 1 - i]) begin
                w_nxt_data[i] = shift_fixed(w_src_data[i], 32'(1) << (int'(SHAMT_W) - 1 - i),
                                            w_src_op[i], w_src_sign[i]);
            end else begin
                w_nxt_data[i] = w_src_data[i];
            end
        end
    end

    // Stage registers: load when ready, otherwise hold; flush only kills valids.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_v[i]     <= 1'b0;
                r_data[i]  <= '0;
                r_shamt[i] <= '0;
                r_op[i]    <= 1'b0;
                r_sign[i]  <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (flush) begin
                    r_v[i] <= 1'b0;
                end else if (w_rdy[i]) begin
                    r_v[i] <= w_src_v[i];
                end
                if (w_rdy[i]) begin
                    r_data[i]  <= w_nxt_data[i];
                    r_shamt[i] <= w_src_shamt[i];
                    r_op[i]    <= w_src_op[i];
                    r_sign[i]  <= w_src_sign[i];
                    r_tag[i]   <= w_src_tag[i];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < int'(STAGES); i++) begin
            busy = busy | r_v[i];
        end
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.out_data  = r_data[STAGES-1];
    assign bus.out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_shift_pipeline.sv
// Directed bench for shift_pipeline with a queue scoreboard of expected results.
module tb_shift_pipeline;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    int rises    = 0;
    logic prev_v = 1'b0;
    exp_t sb[$];

    shift_pipeline_if bus ();

    shift_pipeline dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh, input logic op);
        if (op) return 32'($signed(d) >>> sh);
        return d << sh;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: pop and compare on every output transfer.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) rises++;
            prev_v = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_output observed=%h expected=none", bus.out_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_tag", 32'(bus.out_tag), 32'(e.t));
                end
                n_out++;
            end
            if (flush) sb.delete();
        end
    end

    // Present an op and wait (bounded) for acceptance; valid is left high.
    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic op,
                        input logic [4:0] tag, input logic [31:0] exp);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_op    = op;
        bus.in_tag   = tag;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                sb.push_back('{d: exp, t: tag});
                @(posedge clock); #1;
                return;
            end
            @(posedge clock); #1;
        end
        checks++;
        failures++;
        $error("FAIL send_timeout observed=stalled expected=accepted");
    endtask

    task automatic send_m(input logic [31:0] d, input logic [4:0] sh, input logic op, input logic [4:0] tag);
        send(d, sh, op, tag, model(d, sh, op));
    endtask

    initial begin
        int n0;
        int r0;
        logic [31:0] hold_d;
        logic [4:0]  hold_t;

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'(0));
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clock); #1;

        // 1: reset with 3 ops in flight
        send_m(32'h1234_5678, 5'd3, 1'b0, 5'd1);
        send_m(32'h8765_4321, 5'd7, 1'b1, 5'd2);
        send_m(32'hDEAD_BEEF, 5'd1, 1'b0, 5'd3);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_out_data", bus.out_data, 32'h0);
        @(posedge clock); #1 reset_n = 1'b1;
        n0 = n_out;
        repeat (10) @(negedge clock);
        chk("midrst_no_stale", 32'(n_out - n0), 32'(0));
        @(posedge clock); #1;

        // 2: SLL 0xFF by 20, tag 7, latency 5
        send(32'h0000_00FF, 5'd20, 1'b0, 5'd7, 32'h0FF0_0000);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            chk($sformatf("latency_c%0d", k), 32'(bus.out_valid), 32'(k == 5));
            if (k == 5) chk("sll20_tag", 32'(bus.out_tag), 32'(7));
        end
        @(posedge clock); #1;

        // 3: SRA/SLL edge cases
        send(32'h8000_0000, 5'd31, 1'b1, 5'd1, 32'hFFFF_FFFF);
        send(32'h7FFF_FFFF, 5'd4,  1'b1, 5'd2, 32'h07FF_FFFF);
        send(32'hA5A5_1234, 5'd0,  1'b0, 5'd3, 32'hA5A5_1234);
        send(32'hA5A5_1234, 5'd0,  1'b1, 5'd4, 32'hA5A5_1234);
        send(32'h8000_0001, 5'd31, 1'b0, 5'd5, 32'h8000_0000);
        send(32'hF000_0000, 5'd4,  1'b1, 5'd6, 32'hFF00_0000);
        send(32'h0000_0001, 5'd31, 1'b1, 5'd8, 32'h0000_0000);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clock);
        @(posedge clock); #1;

        // 4: back-to-back stream of 10, shamt 0..9
        n0 = n_out;
        r0 = rises;
        for (int i = 0; i < 10; i++) begin
            send_m($urandom, 5'(i), 1'(i), 5'(i + 10));
        end
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clock);
        chk("stream_count", 32'(n_out - n0), 32'(10));
        chk("stream_contiguous", 32'(rises - r0), 32'(1));
        @(posedge clock); #1;

        // 5: output stall with 6 ops offered
        n0 = n_out;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_m($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 5'(i + 20));
        end
        bus.in_data = 32'hC0DE_0006;
        @(negedge clock);
        chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
        chk("stall_busy", 32'(busy), 32'(1));
        chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
        hold_d = bus.out_data;
        hold_t = bus.out_tag;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_hold_valid", 32'(bus.out_valid), 32'(1));
            chk("stall_hold_data", bus.out_data, hold_d);
            chk("stall_hold_tag", 32'(bus.out_tag), 32'(hold_t));
        end
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        send_m(32'hC0DE_0006, 5'd13, 1'b1, 5'd26);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clock);
        chk("stall_drain_count", 32'(n_out - n0), 32'(6));
        @(posedge clock); #1;

        // 6: flush with in_valid and 3 ops in flight
        send_m(32'h1111_1111, 5'd2, 1'b0, 5'd1);
        send_m(32'h2222_2222, 5'd5, 1'b1, 5'd2);
        send_m(32'h3333_3333, 5'd9, 1'b0, 5'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4444_4444;
        flush        = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clock); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("flush_busy", 32'(busy), 32'(0));
        chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
        n0 = n_out;
        repeat (10) @(negedge clock);
        chk("flush_no_output", 32'(n_out - n0), 32'(0));
        @(posedge clock); #1;
        send_m(32'h8000_00F0, 5'd6, 1'b1, 5'd9);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clock);
        chk("post_flush_count", 32'(n_out - n0), 32'(1));

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
